// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of fifo_mem between
// NREQ producers. One producer owns the port for a burst of up to MAX_BURST
// words; fifo_full stalls the burst without revoking ownership.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; pick next requester from rr_ptr (1-cycle bubble)
//   GRANT | owner may transfer; leave on burst limit or req release
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4,
   parameter int OW        = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*DW-1:0] din,
   output logic [NREQ-1:0]   gnt,
   input  logic              fifo_full,
   output logic              fifo_wr,
   output logic [DW-1:0]     fifo_data,
   output logic              busy,
   output logic [OW-1:0]     owner,
   output logic [15:0]       wr_count
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
   localparam logic [OW-1:0] LAST_IDX = OW'(NREQ - 1);

   state_t        state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] rr_ptr_q, rr_ptr_d;
   logic [3:0]    beat_cnt_q, beat_cnt_d;
   logic [15:0]   wr_count_q, wr_count_d;

   logic [OW-1:0] pick;
   logic [OW-1:0] owner_inc;
   logic          owner_req;
   logic          xfer;

   // Rotating priority search: first requester at or above rr_ptr, wrapping.
   always_comb begin
      int  idx;
      logic found;
      pick  = rr_ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            pick  = OW'(idx);
            found = 1'b1;
         end
      end
   end

   // Transfer qualification and port-facing outputs, all zero-latency.
   always_comb begin
      owner_req = req[owner_q];
      owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
      xfer      = (state_q == GRANT) && owner_req && !fifo_full;
      gnt       = xfer ? (NREQ'(1) << owner_q) : '0;
      fifo_wr   = xfer;
      fifo_data = xfer ? din[int'(owner_q)*DW +: DW] : '0;
      busy      = (state_q == GRANT);
      owner     = owner_q;
      wr_count  = wr_count_q;
   end

   // Next-state logic: arbitration in IDLE, burst accounting in GRANT.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      wr_count_d = wr_count_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               owner_d    = pick;
               beat_cnt_d = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               state_d  = IDLE;
               rr_ptr_d = owner_inc;
            end else if (xfer) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               wr_count_d = wr_count_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d  = IDLE;
                  rr_ptr_d = owner_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         wr_count_q <= wr_count_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven producers, a small fifo_mem model,
// and a scoreboard that checks every write the arbiter issues.
module tb_fifo_wr_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int OW   = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*DW-1:0] din = '0;
   logic [NREQ-1:0]   gnt;
   logic              fifo_full;
   logic              fifo_wr;
   logic [DW-1:0]     fifo_data;
   logic              busy;
   logic [OW-1:0]     owner;
   logic [15:0]       wr_count;

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt),
      .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
      .busy(busy), .owner(owner), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          prod;
      logic [7:0]  data;
      logic [15:0] wc;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  pq[NREQ][$];
   int          nvec = 0, nerr = 0;
   int          cyc = 0, wr_seen = 0, first_wr = -1, last_wr = -1;
   logic [15:0] mdl_wc = '0;
   int          mcount = 0, rd_pending = 0;
   bit          auto_rd = 1'b1, ovf = 1'b0, stall = 1'b0;
   logic [NREQ-1:0] gnt_s = '0;
   logic        wr_s = 1'b0;

   assign fifo_full = (mcount >= 16) || stall;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic load(input int p, input logic [7:0] d);
      pq[p].push_back(d);
   endtask

   task automatic expect_wr(input int p, input logic [7:0] d);
      exp_q.push_back('{prod: p, data: d, wc: mdl_wc});
      mdl_wc++;
   endtask

   always @(posedge clk) cyc++;

   // Producers: present head word, pop it after a gnt seen at the previous edge.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
         req[i] = (pq[i].size() > 0);
         din[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
      end
   end

   // fifo_mem occupancy model.
   always @(posedge clk) begin
      #1;
      if (wr_s) begin
         if (mcount >= 16) ovf = 1'b1;
         else mcount++;
      end
      if ((auto_rd || rd_pending > 0) && mcount > 0) begin
         mcount--;
         if (rd_pending > 0) rd_pending--;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin : mon
      exp_t e;
      gnt_s = gnt;
      wr_s  = fifo_wr;
      if (rst_n) begin
         if (fifo_wr) begin
            wr_seen++;
            last_wr = cyc;
            if (first_wr < 0) first_wr = cyc;
            if (exp_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_write: got data %0h owner %0d expected none", fifo_data, owner);
            end else begin
               e = exp_q.pop_front();
               chk("wr_data", 32'(fifo_data), 32'(e.data));
               chk("wr_gnt", 32'(gnt), 32'(1) << e.prod);
               chk("wr_owner", 32'(owner), 32'(e.prod));
               chk("wr_count_pre", 32'(wr_count), 32'(e.wc));
               chk("wr_while_full", 32'(fifo_full), 0);
            end
         end else begin
            chk("gnt_without_wr", 32'(gnt), 0);
         end
      end
   end

   task automatic wait_writes(input int target, input string nm);
      int n = 0;
      while (wr_seen < target && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      chk(nm, 32'(wr_seen >= target), 1);
   endtask

   task automatic wait_done(input string nm);
      int  n = 0;
      bit  done = 1'b0;
      while (!done && n < 300) begin
         @(negedge clk); #1;
         n++;
         done = (exp_q.size() == 0) && !busy && (req == '0);
      end
      chk(nm, 32'(done), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) pq[i].delete();
      exp_q.delete();
      mdl_wc = '0;
      mcount = 0;
      stall  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int load_cyc, base;

      // Reset values
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_wr", 32'(fifo_wr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wc", 32'(wr_count), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_owner", 32'(owner), 0);
      chk("post_rst_data", 32'(fifo_data), 0);

      // Test 1: single producer, 3 words, released after the third
      load_cyc = cyc; first_wr = -1;
      for (int k = 0; k < 3; k++) begin
         load(0, 8'hA0 + 8'(k));
         expect_wr(0, 8'hA0 + 8'(k));
      end
      wait_done("t1_done");
      chk("t1_bubble", 32'(first_wr - load_cyc), 2);
      chk("t1_consecutive", 32'(last_wr - first_wr), 2);
      chk("t1_rr_ptr", 32'(dut.rr_ptr_q), 1);
      chk("t1_wc", 32'(wr_count), 3);

      // Test 2: all four requesting, order 0,1,2,3,0 with 4-word bursts
      do_reset();
      load_cyc = cyc; first_wr = -1;
      for (int p = 0; p < NREQ; p++)
         for (int k = 0; k < ((p == 0) ? 8 : 4); k++) load(p, 8'((p + 1) * 16 + k));
      for (int p = 0; p < NREQ; p++)
         for (int k = 0; k < 4; k++) expect_wr(p, 8'((p + 1) * 16 + k));
      for (int k = 4; k < 8; k++) expect_wr(0, 8'(16 + k));
      wait_done("t2_done");
      chk("t2_first", 32'(first_wr - load_cyc), 2);
      chk("t2_span", 32'(last_wr - first_wr), 23);
      chk("t2_wc", 32'(wr_count), 20);
      chk("t2_rr_ptr", 32'(dut.rr_ptr_q), 1);

      // Test 3: owner 2 stalls 5 cycles after its second word
      base = wr_seen;
      for (int k = 0; k < 4; k++) begin
         load(2, 8'hC0 + 8'(k));
         expect_wr(2, 8'hC0 + 8'(k));
      end
      wait_writes(base + 2, "t3_two_words");
      @(posedge clk); #2;
      stall = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         chk("t3_stall_wr", 32'(fifo_wr), 0);
         chk("t3_stall_gnt", 32'(gnt), 0);
         chk("t3_stall_busy", 32'(busy), 1);
         chk("t3_stall_owner", 32'(owner), 2);
         chk("t3_stall_beat", 32'(dut.beat_cnt_q), 2);
      end
      @(posedge clk); #2;
      stall = 1'b0;
      wait_done("t3_done");
      chk("t3_writes", 32'(wr_seen - base), 4);
      chk("t3_rr_ptr", 32'(dut.rr_ptr_q), 3);

      // Test 4: fifo holds 14, producer 0 sends 4, two reads free the rest
      auto_rd = 1'b0;
      mcount  = 14;
      base    = wr_seen;
      for (int k = 0; k < 4; k++) begin
         load(0, 8'hD0 + 8'(k));
         expect_wr(0, 8'hD0 + 8'(k));
      end
      wait_writes(base + 2, "t4_two_words");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk("t4_full", 32'(fifo_full), 1);
         chk("t4_stall_wr", 32'(fifo_wr), 0);
         chk("t4_stall_busy", 32'(busy), 1);
      end
      chk("t4_writes_before_read", 32'(wr_seen - base), 2);
      rd_pending = 2;
      wait_done("t4_done");
      chk("t4_writes", 32'(wr_seen - base), 4);
      chk("t4_level", 32'(mcount), 16);
      chk("t4_overflow", 32'(ovf), 0);
      auto_rd = 1'b1;

      // Test 5: reset in the middle of a burst from producer 1
      base = wr_seen;
      for (int k = 0; k < 4; k++) begin
         load(1, 8'hE0 + 8'(k));
         expect_wr(1, 8'hE0 + 8'(k));
      end
      wait_writes(base + 1, "t5_one_word");
      @(posedge clk); #2;
      chk("t5_inflight", 32'(fifo_wr), 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_gnt", 32'(gnt), 0);
      chk("t5_rst_wr", 32'(fifo_wr), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_wc", 32'(wr_count), 0);
      chk("t5_pending", 32'(exp_q.size()), 3);
      exp_q.delete();
      pq[1].delete();
      mdl_wc = '0;
      mcount = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("t5_busy", 32'(busy), 0);
      chk("t5_wc", 32'(wr_count), 0);
      chk("t5_owner", 32'(owner), 0);
      chk("t5_rr_ptr", 32'(dut.rr_ptr_q), 0);

      // Test 6: wr_count wraps 65535 -> 0
      force dut.wr_count_q = 16'd65534;
      #1;
      release dut.wr_count_q;
      mdl_wc = 16'd65534;
      @(negedge clk); #1;
      chk("t6_preload", 32'(wr_count), 65534);
      for (int k = 0; k < 3; k++) begin
         load(2, 8'hF0 + 8'(k));
         expect_wr(2, 8'hF0 + 8'(k));
      end
      wait_done("t6_done");
      chk("t6_wc_wrapped", 32'(wr_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
